// File: rtl/ft_pkg.sv
// Fault-tolerance package: compressed-decoder breakage monitor constants,
// reconfiguration FSM state type and a lowest-set-index helper.
package ft_pkg;

    localparam int unsigned CDEC_INCREMENT          = 1;
    localparam int unsigned CDEC_DECREMENT          = 1;
    localparam int unsigned CDEC_BREAKING_THRESHOLD = 3;
    localparam int unsigned CDEC_COUNT_BIT          = 8;
    localparam int unsigned CDEC_INC_DEC_BIT        = 2;

    typedef enum logic [1:0] {BM_IDLE, BM_REQ, BM_GAP} cdec_bm_state_e;

    // Index of the lowest set bit; 0 when nothing is set.
    function automatic logic [2:0] lowest_set(input logic [7:0] v);
        logic [2:0] res;
        res = '0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) res = i[2:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/cdec_bm_counter.sv
// One replica's saturating up/down mismatch counter with a sticky broken flag.
// The counter freezes once the replica is declared broken.
module cdec_bm_counter
    import ft_pkg::*;
#(
    parameter int unsigned INCREMENT          = CDEC_INCREMENT,
    parameter int unsigned DECREMENT          = CDEC_DECREMENT,
    parameter int unsigned BREAKING_THRESHOLD = CDEC_BREAKING_THRESHOLD,
    parameter int unsigned COUNT_BIT          = CDEC_COUNT_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 valid,
    input  logic                 err,
    output logic [COUNT_BIT-1:0] cnt,
    output logic                 broken,
    output logic                 broken_next
);

    localparam logic [COUNT_BIT:0] INC_W = (COUNT_BIT+1)'(INCREMENT);
    localparam logic [COUNT_BIT:0] DEC_W = (COUNT_BIT+1)'(DECREMENT);
    localparam logic [COUNT_BIT:0] THR_W = (COUNT_BIT+1)'(BREAKING_THRESHOLD);
    localparam logic [COUNT_BIT:0] MAX_W = {1'b0, {COUNT_BIT{1'b1}}};

    logic [COUNT_BIT:0]   sum;
    logic [COUNT_BIT-1:0] cnt_next;

    // Next count: increment saturates at all-ones, decrement floors at zero.
    always_comb begin
        sum      = {1'b0, cnt} + INC_W;
        cnt_next = cnt;
        if (!broken && valid) begin
            if (err)
                cnt_next = (sum > MAX_W) ? MAX_W[COUNT_BIT-1:0] : sum[COUNT_BIT-1:0];
            else
                cnt_next = ({1'b0, cnt} >= DEC_W) ? (cnt - DEC_W[COUNT_BIT-1:0]) : '0;
        end
        broken_next = broken | ({1'b0, cnt_next} >= THR_W);
    end

    // Counter and sticky flag; clear behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt    <= '0;
            broken <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            broken <= broken_next;
        end
    end

endmodule

// File: rtl/cdec_breakage_monitor.sv
// Breakage monitor for the triplicated compressed decoder: per-replica
// mismatch scoring, fatal loss-of-masking flag, and one reconfiguration
// request per newly broken replica over a req/ack handshake.
module cdec_breakage_monitor
    import ft_pkg::*;
#(
    parameter int unsigned N_REPLICA          = 3,
    parameter int unsigned INCREMENT          = CDEC_INCREMENT,
    parameter int unsigned DECREMENT          = CDEC_DECREMENT,
    parameter int unsigned BREAKING_THRESHOLD = CDEC_BREAKING_THRESHOLD,
    parameter int unsigned COUNT_BIT          = CDEC_COUNT_BIT,
    parameter int unsigned INC_DEC_BIT        = CDEC_INC_DEC_BIT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_i,
    input  logic [N_REPLICA-1:0]           err_i,
    input  logic                           clear_i,
    output logic [N_REPLICA-1:0]           broken_o,
    output logic                           fatal_o,
    output logic [N_REPLICA*COUNT_BIT-1:0] cnt_o,
    output logic                           reconfig_req_o,
    output logic [2:0]                     reconfig_id_o,
    input  logic                           reconfig_ack_i
);

    if (N_REPLICA < 2 || N_REPLICA > 8) begin : g_chk_n
        $error("N_REPLICA must be in 2..8");
    end
    if (BREAKING_THRESHOLD < 1 || BREAKING_THRESHOLD > (2**COUNT_BIT) - 1) begin : g_chk_thr
        $error("BREAKING_THRESHOLD must be in 1..2^COUNT_BIT-1");
    end
    if (INCREMENT >= 2**INC_DEC_BIT || DECREMENT >= 2**INC_DEC_BIT) begin : g_chk_incdec
        $error("INCREMENT/DECREMENT must fit in INC_DEC_BIT bits");
    end

    logic [N_REPLICA-1:0][COUNT_BIT-1:0] cnt_arr;
    logic [N_REPLICA-1:0]                broken_next;
    logic [N_REPLICA-1:0]                reported;
    logic [N_REPLICA-1:0]                pending;
    logic [N_REPLICA-1:0]                id_mask;
    logic [7:0]                          pending8;
    logic [3:0]                          nb_cnt;
    cdec_bm_state_e                      state;

    for (genvar k = 0; k < N_REPLICA; k++) begin : g_rep
        cdec_bm_counter #(
            .INCREMENT          (INCREMENT),
            .DECREMENT          (DECREMENT),
            .BREAKING_THRESHOLD (BREAKING_THRESHOLD),
            .COUNT_BIT          (COUNT_BIT)
        ) u_cnt (
            .clk         (clk),
            .rst         (rst),
            .clear       (clear_i),
            .valid       (valid_i),
            .err         (err_i[k]),
            .cnt         (cnt_arr[k]),
            .broken      (broken_o[k]),
            .broken_next (broken_next[k])
        );
    end

    assign cnt_o   = cnt_arr;
    assign pending = broken_o & ~reported;

    // Popcount of next broken flags, pending widened for the index helper,
    // and a one-hot of the replica currently being reported.
    always_comb begin
        nb_cnt   = '0;
        pending8 = '0;
        id_mask  = '0;
        for (int k = 0; k < N_REPLICA; k++) begin
            nb_cnt      = nb_cnt + 4'(broken_next[k]);
            pending8[k] = pending[k];
            id_mask[k]  = (reconfig_id_o == 3'(k));
        end
    end

    // Fatal flag: two or more replicas broken, registered alongside broken_o.
    always_ff @(posedge clk) begin
        if (rst || clear_i) fatal_o <= 1'b0;
        else                fatal_o <= fatal_o | (nb_cnt >= 4'd2);
    end

    // Reconfiguration handshake. GAP re-arbitrates directly so consecutive
    // requests are separated by exactly one req-low cycle.
    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            state          <= BM_IDLE;
            reconfig_req_o <= 1'b0;
            reconfig_id_o  <= '0;
            reported       <= '0;
        end else begin
            case (state)
                BM_IDLE, BM_GAP: begin
                    if (pending != '0) begin
                        state          <= BM_REQ;
                        reconfig_req_o <= 1'b1;
                        reconfig_id_o  <= lowest_set(pending8);
                    end else begin
                        state          <= BM_IDLE;
                        reconfig_req_o <= 1'b0;
                    end
                end
                BM_REQ: begin
                    if (reconfig_ack_i) begin
                        state          <= BM_GAP;
                        reconfig_req_o <= 1'b0;
                        reported       <= reported | id_mask;
                    end
                end
                default: begin
                    state          <= BM_IDLE;
                    reconfig_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cdec_breakage_monitor.sv
// Directed bench for cdec_breakage_monitor: default configuration plus a
// narrow-counter instance to exercise increment saturation.
module tb_cdec_breakage_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [2:0]  err = '0;
    logic        clear = 1'b0;
    logic        ack = 1'b0;
    logic [2:0]  broken;
    logic        fatal;
    logic [23:0] cnt;
    logic        req;
    logic [2:0]  id;

    logic        valid_b = 1'b0;
    logic [1:0]  err_b = '0;
    logic        clear_b = 1'b0;
    logic        ack_b = 1'b0;
    logic [1:0]  broken_b;
    logic        fatal_b;
    logic [3:0]  cnt_b;
    logic        req_b;
    logic [2:0]  id_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cdec_breakage_monitor u_dut (
        .clk(clk), .rst(rst), .valid_i(valid), .err_i(err), .clear_i(clear),
        .broken_o(broken), .fatal_o(fatal), .cnt_o(cnt),
        .reconfig_req_o(req), .reconfig_id_o(id), .reconfig_ack_i(ack)
    );

    cdec_breakage_monitor #(
        .N_REPLICA(2), .INCREMENT(2), .DECREMENT(1),
        .BREAKING_THRESHOLD(3), .COUNT_BIT(2), .INC_DEC_BIT(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .valid_i(valid_b), .err_i(err_b), .clear_i(clear_b),
        .broken_o(broken_b), .fatal_o(fatal_b), .cnt_o(cnt_b),
        .reconfig_req_o(req_b), .reconfig_id_o(id_b), .reconfig_ack_i(ack_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_all_zero(input string tag);
        chk({tag, "_broken"}, 32'(broken), 0);
        chk({tag, "_fatal"}, 32'(fatal), 0);
        chk({tag, "_cnt"}, 32'(cnt), 0);
        chk({tag, "_req"}, 32'(req), 0);
        chk({tag, "_id"}, 32'(id), 0);
    endtask

    initial begin
        // 1: reset dominates a valid all-error sample
        rst = 1'b1; valid = 1'b1; err = 3'b111;
        valid_b = 1'b1; err_b = 2'b11;
        tick(); tick();
        chk_idle_all_zero("rst");
        chk("rst_cnt_b", 32'(cnt_b), 0);
        rst = 1'b0; valid = 1'b0; err = '0; valid_b = 1'b0; err_b = '0;
        tick();
        chk_idle_all_zero("rst_rel");

        // 2: replica 0 breaks after three errors, request held until ack
        valid = 1'b1; err = 3'b001;
        tick(); chk("t2_cnt0_1", 32'(cnt[7:0]), 1); chk("t2_brk_1", 32'(broken), 0);
        tick(); chk("t2_cnt0_2", 32'(cnt[7:0]), 2); chk("t2_brk_2", 32'(broken), 0);
        tick(); chk("t2_cnt0_3", 32'(cnt[7:0]), 3); chk("t2_brk_3", 32'(broken), 3'b001);
        chk("t2_req_pre", 32'(req), 0);
        chk("t2_fatal", 32'(fatal), 0);
        valid = 1'b1; err = 3'b001;
        tick(); chk("t2_req", 32'(req), 1); chk("t2_id", 32'(id), 0);
        chk("t2_frozen", 32'(cnt[7:0]), 3);
        valid = 1'b0; err = '0;
        for (int i = 0; i < 5; i++) begin
            tick(); chk("t2_req_hold", 32'(req), 1); chk("t2_id_hold", 32'(id), 0);
        end
        ack = 1'b1;
        tick(); ack = 1'b0;
        chk("t2_req_drop", 32'(req), 0);
        for (int i = 0; i < 3; i++) begin
            tick(); chk("t2_req_stay0", 32'(req), 0);
        end

        // 3: replica 1 toggles; invalid cycles hold; no wrap below zero
        for (int i = 0; i < 20; i++) begin
            valid = 1'b1; err = (i % 2 == 0) ? 3'b010 : 3'b000;
            tick(); chk("t3_cnt1", 32'(cnt[15:8]), (i % 2 == 0) ? 1 : 0);
            valid = 1'b0; err = 3'b111;
            tick(); chk("t3_cnt1_hold", 32'(cnt[15:8]), (i % 2 == 0) ? 1 : 0);
        end
        chk("t3_broken", 32'(broken), 3'b001);
        chk("t3_cnt2", 32'(cnt[23:16]), 0);
        valid = 1'b1; err = 3'b000;
        tick(); chk("t3_nowrap", 32'(cnt[15:8]), 0);
        valid = 1'b0; err = '0;

        // 4: simultaneous break of 0 and 2, fatal, served 0 then 2
        clear = 1'b1; tick(); clear = 1'b0;
        chk_idle_all_zero("t4_clr");
        valid = 1'b1; err = 3'b101;
        tick(); tick();
        chk("t4_cnt0_2", 32'(cnt[7:0]), 2); chk("t4_cnt2_2", 32'(cnt[23:16]), 2);
        chk("t4_brk_pre", 32'(broken), 0); chk("t4_fatal_pre", 32'(fatal), 0);
        tick();
        chk("t4_brk", 32'(broken), 3'b101); chk("t4_fatal", 32'(fatal), 1);
        valid = 1'b0; err = '0;
        tick(); chk("t4_req0", 32'(req), 1); chk("t4_id0", 32'(id), 0);
        tick(); chk("t4_req0_hold", 32'(req), 1); chk("t4_id0_hold", 32'(id), 0);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t4_gap", 32'(req), 0);
        tick(); chk("t4_req2", 32'(req), 1); chk("t4_id2", 32'(id), 2);
        ack = 1'b1; tick(); ack = 1'b0;
        chk("t4_req2_drop", 32'(req), 0);
        tick(); tick(); chk("t4_done", 32'(req), 0);
        chk("t4_fatal_sticky", 32'(fatal), 1);

        // 5: narrow counter saturates at 3 instead of wrapping
        valid_b = 1'b1; err_b = 2'b01;
        tick(); chk("t5_cnt_2", 32'(cnt_b[1:0]), 2); chk("t5_brk_pre", 32'(broken_b), 0);
        tick(); chk("t5_cnt_sat", 32'(cnt_b[1:0]), 3); chk("t5_brk", 32'(broken_b), 2'b01);
        tick(); chk("t5_cnt_frozen", 32'(cnt_b[1:0]), 3);
        valid_b = 1'b0; err_b = '0;

        // 6: clear beats a simultaneous ack; reported stays clear
        clear = 1'b1; tick(); clear = 1'b0;
        valid = 1'b1; err = 3'b001;
        tick(); tick(); tick();
        valid = 1'b0; err = '0;
        tick(); chk("t6_req", 32'(req), 1); chk("t6_id", 32'(id), 0);
        clear = 1'b1; ack = 1'b1;
        tick(); clear = 1'b0; ack = 1'b0;
        chk_idle_all_zero("t6_clr");
        for (int i = 0; i < 3; i++) begin
            tick(); chk("t6_no_req", 32'(req), 0);
        end
        valid = 1'b1; err = 3'b001;
        tick(); tick(); tick();
        valid = 1'b0; err = '0;
        tick(); chk("t6_rereq", 32'(req), 1); chk("t6_reid", 32'(id), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
